// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the ID/EX hazard controller: FSM states, EX-slot control bits, counter widths.
// Imported by the hazard controller and by the ID/EX stage logic that mirrors the EX slot.
package hazard_ctrl_pkg;

   localparam int DEF_SIZE = 32;
   // Wide enough for any legal multi-cycle latency (1..255).
   localparam int MC_CNT_W = 8;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
   } ex_ctl_t;

   localparam ex_ctl_t EX_CTL_NOP = '0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Generic up-counter that sticks at all-ones instead of wrapping.
// One increment per cycle while inc_i is high; cleared by synchronous reset.
module hazard_ctrl_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage datapath: load-use stall, multi-cycle EX occupancy, branch flush.
// Control outputs are combinational from the EX-slot/FSM registers and the current ID fields.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int  SIZE   = DEF_SIZE,
   parameter int  MC_LAT = 4,
   parameter int  CNT_W  = 16,
   localparam int RW     = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RW-1:0]    id_rs,
   input  logic [RW-1:0]    id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_reg_write,
   input  logic [RW-1:0]    id_write_reg,
   input  logic             id_mem_read,
   input  logic             id_multicycle,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_busy,
   output logic [CNT_W-1:0] stall_count
);

   localparam bit                  MC_EN   = (MC_LAT > 1);
   localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 1);

   state_t               state_q, state_d;
   ex_ctl_t              ex_q, ex_d;
   logic [RW-1:0]        ex_wr_q, ex_wr_d;
   logic [MC_CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
   logic                 load_use;
   logic                 stall_inc;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_wr_q != '0) &&
                     id_valid && ((id_use_rs && (id_rs == ex_wr_q)) ||
                                  (id_use_rt && (id_rt == ex_wr_q)));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_busy      = 1'b0;
      state_d      = state_q;
      ex_d         = ex_q;
      ex_wr_d      = ex_wr_q;
      mc_cnt_d     = mc_cnt_q;
      if (!reset) begin
         case (state_q)
            RUN: begin
               if (ex_branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  ex_d         = EX_CTL_NOP;
                  ex_wr_d      = '0;
               end else if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  ex_d         = EX_CTL_NOP;
                  ex_wr_d      = '0;
               end else begin
                  ex_d.valid     = id_valid;
                  ex_d.reg_write = id_reg_write;
                  ex_d.mem_read  = id_mem_read;
                  ex_wr_d        = id_write_reg;
                  if (MC_EN && id_valid && id_multicycle) begin
                     state_d  = MC_BUSY;
                     mc_cnt_d = MC_LOAD;
                  end
               end
            end
            MC_BUSY: begin
               // ID_EX holds the op in flight, so no bubble; branches cannot resolve here.
               ex_busy     = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               mc_cnt_d    = mc_cnt_q - 1'b1;
               if (mc_cnt_q == MC_CNT_W'(1)) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         ex_q     <= EX_CTL_NOP;
         ex_wr_q  <= '0;
         mc_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ex_q     <= ex_d;
         ex_wr_q  <= ex_wr_d;
         mc_cnt_q <= mc_cnt_d;
      end
   end

   assign stall_inc = ~pc_write;

   hazard_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (stall_inc),
      .count_o (stall_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, a pending-load/busy-cycles model checked
// every cycle, and literal checkpoints; a second small-counter instance exercises saturation.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_multicycle;
   logic [4:0] id_rs, id_rt, id_write_reg;
   logic       ex_branch_taken;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_busy;
   logic [15:0] stall_count;
   logic        pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, ex_busy2;
   logic [7:0]  stall_count2;

   int nvec = 0;
   int nbad = 0;

   // Model: remaining busy cycles, and the destination of a load sitting in EX (if any).
   int         m_mc_left = 0;
   bit         m_ld_pend = 1'b0;
   logic [4:0] m_ld_dst  = '0;
   int         m_stall   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.SIZE(32), .MC_LAT(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_busy(ex_busy),
      .stall_count(stall_count)
   );

   hazard_ctrl #(.SIZE(32), .MC_LAT(255), .CNT_W(8)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write2), .if_id_write(if_id_write2),
      .if_id_flush(if_id_flush2), .id_ex_bubble(id_ex_bubble2), .ex_busy(ex_busy2),
      .stall_count(stall_count2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every cycle, then advance the model with the inputs that the next edge will sample.
   always @(negedge clk) begin
      bit lu, e_pc, e_ifid, e_fl, e_bub, e_busy;
      lu = m_ld_pend && id_valid &&
           ((id_use_rs && id_rs == m_ld_dst) || (id_use_rt && id_rt == m_ld_dst));
      e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_busy = 0;
      if (reset) begin
      end else if (m_mc_left > 0) begin
         e_busy = 1; e_pc = 0; e_ifid = 0;
      end else if (ex_branch_taken) begin
         e_fl = 1; e_bub = 1;
      end else if (lu) begin
         e_pc = 0; e_ifid = 0; e_bub = 1;
      end
      chk("pc_write",     pc_write,     e_pc);
      chk("if_id_write",  if_id_write,  e_ifid);
      chk("if_id_flush",  if_id_flush,  e_fl);
      chk("id_ex_bubble", id_ex_bubble, e_bub);
      chk("ex_busy",      ex_busy,      e_busy);
      chk("stall_count",  stall_count,  m_stall);

      if (reset) begin
         m_mc_left = 0; m_ld_pend = 0; m_stall = 0;
      end else begin
         if (!e_pc && m_stall < 65535) m_stall++;
         if (m_mc_left > 0) begin
            m_mc_left--;
         end else if (ex_branch_taken || lu) begin
            m_ld_pend = 0;
         end else begin
            m_ld_pend = id_valid && id_mem_read && id_reg_write && (id_write_reg != 0);
            m_ld_dst  = id_write_reg;
            if (id_valid && id_multicycle) m_mc_left = 4 - 1;
         end
      end
   end

   task automatic set_id(input bit v, input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                         input bit urt, input bit rw, input bit [4:0] wr, input bit mr,
                         input bit mc);
      id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
      id_reg_write = rw; id_write_reg = wr; id_mem_read = mr; id_multicycle = mc;
   endtask

   task automatic mid;
      @(negedge clk); #1;
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; ex_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt; nxt;
      reset = 1'b0;
      mid;
      chk("idle pc_write", pc_write, 1);
      chk("idle if_id_write", if_id_write, 1);
      chk("idle flush", if_id_flush, 0);
      chk("idle bubble", id_ex_bubble, 0);
      chk("idle stall_count", stall_count, 0);
      nxt;

      // lw $5 followed by add reading $5: one stall cycle
      set_id(1, 0, 0, 0, 0, 1, 5, 1, 0); nxt;
      set_id(1, 5, 1, 6, 1, 1, 7, 0, 0);
      mid;
      chk("lu pc_write", pc_write, 0);
      chk("lu if_id_write", if_id_write, 0);
      chk("lu bubble", id_ex_bubble, 1);
      nxt; mid;
      chk("lu retry pc_write", pc_write, 1);
      chk("lu retry bubble", id_ex_bubble, 0);
      chk("lu stall_count", stall_count, 1);
      nxt;

      // lw $0 then read of $0: no hazard
      set_id(1, 0, 0, 0, 0, 1, 0, 1, 0); nxt;
      set_id(1, 0, 1, 3, 1, 1, 4, 0, 0);
      mid; chk("r0 pc_write", pc_write, 1); nxt;

      // lw $6 then instruction whose unused rs field happens to be 6
      set_id(1, 0, 0, 0, 0, 1, 6, 1, 0); nxt;
      set_id(1, 6, 0, 2, 1, 1, 3, 0, 0);
      mid; chk("unused rs pc_write", pc_write, 1); nxt;

      // mul: three busy cycles, then RUN
      set_id(1, 1, 1, 2, 1, 1, 8, 0, 1); nxt;
      set_id(1, 8, 1, 9, 1, 1, 10, 0, 0);
      mid;
      chk("mc ex_busy", ex_busy, 1);
      chk("mc pc_write", pc_write, 0);
      chk("mc bubble", id_ex_bubble, 0);
      nxt; nxt; nxt; mid;
      chk("mc done ex_busy", ex_busy, 0);
      chk("mc done pc_write", pc_write, 1);
      chk("mc stall_count", stall_count, 4);
      nxt;

      // branch while busy is ignored
      set_id(1, 1, 1, 2, 1, 1, 8, 0, 1); nxt;
      set_id(1, 3, 1, 4, 1, 1, 5, 0, 0);
      ex_branch_taken = 1'b1;
      mid; chk("mc branch flush", if_id_flush, 0); nxt;
      ex_branch_taken = 1'b0;
      nxt; nxt;

      // load-use coinciding with a taken branch: flush wins, no stall counted
      set_id(1, 0, 0, 0, 0, 1, 9, 1, 0); nxt;
      set_id(1, 1, 0, 9, 1, 1, 11, 0, 0);
      ex_branch_taken = 1'b1;
      mid;
      chk("br+lu flush", if_id_flush, 1);
      chk("br+lu bubble", id_ex_bubble, 1);
      chk("br+lu pc_write", pc_write, 1);
      chk("br+lu if_id_write", if_id_write, 1);
      nxt;
      ex_branch_taken = 1'b0;
      mid;
      chk("br+lu stall_count", stall_count, 7);
      chk("br+lu after pc_write", pc_write, 1);
      nxt;

      // reset in the second busy cycle
      set_id(1, 1, 1, 2, 1, 1, 8, 0, 1); nxt;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt;
      reset = 1'b1;
      mid;
      chk("rst cycle pc_write", pc_write, 1);
      chk("rst cycle ex_busy", ex_busy, 0);
      nxt;
      reset = 1'b0;
      mid;
      chk("post rst ex_busy", ex_busy, 0);
      chk("post rst stall_count", stall_count, 0);
      chk("post rst pc_write", pc_write, 1);
      nxt;

      // saturation on the 8-bit, MC_LAT=255 instance
      reset = 1'b1; nxt;
      reset = 1'b0;
      set_id(1, 1, 1, 2, 1, 1, 8, 0, 1);
      repeat (255) nxt;
      mid;
      chk("sat first op count", stall_count2, 254);
      chk("sat first op ex_busy", ex_busy2, 0);
      nxt;
      repeat (300) nxt;
      mid; chk("sat count", stall_count2, 8'hFF); nxt;
      repeat (10) nxt;
      mid; chk("sat hold", stall_count2, 8'hFF);
      nxt;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath; sits beside the ID stage.
- Decides each cycle whether PC and IF_ID advance, whether ID_EX takes a bubble, and whether IF_ID is flushed.
- Tracks the instruction held in EX (load-use hazards, multi-cycle ops) and reacts to taken branches resolved in EX.
- Forwarding from MEM/WB exists elsewhere, so only load-use and multi-cycle occupancy cause stalls.

Parameters:
- SIZE, 32, register count and datapath width; register index width RW = $clog2(SIZE)
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op (mul/div); legal range 1..255
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RW  source register 1 of ID instruction
- id_rt  in  RW  source register 2 of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_reg_write  in  1  ID instruction writes a register
- id_write_reg  in  RW  destination register of ID instruction
- id_mem_read  in  1  ID instruction is a load
- id_multicycle  in  1  ID instruction is a multi-cycle EX op
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- pc_write  out  1  PC may update
- if_id_write  out  1  IF_ID may load
- if_id_flush  out  1  IF_ID loads a NOP
- id_ex_bubble  out  1  ID_EX loads zeroed control (NOP)
- ex_busy  out  1  multi-cycle op occupying EX
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Control outputs are combinational from registered state plus current inputs. stall_count and internal state are registered.
- EX-slot register holds ex_valid, ex_reg_write, ex_write_reg, ex_mem_read.
- State machine: RUN, MC_BUSY.
- Reset: state=RUN, EX slot cleared, counter=0, stall_count=0. The reset cycle itself drives pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_busy=0.
- load_use = ex_valid & ex_mem_read & ex_reg_write & ex_write_reg!=0 & id_valid & ((id_use_rs & id_rs==ex_write_reg) | (id_use_rt & id_rt==ex_write_reg)).
- Priority in RUN (highest first):
  - ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. EX slot cleared next cycle. A concurrent load_use is ignored.
  - load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. EX slot cleared, so the stall lasts exactly 1 cycle.
  - Otherwise issue: all advance. EX slot loads the ID fields (ex_valid=id_valid).
- MC entry: on issue with id_valid & id_multicycle & MC_LAT>1, go to MC_BUSY and load counter=MC_LAT-1. The EX slot captures the op.
- MC_BUSY:
  - Outputs: ex_busy=1, pc_write=0, if_id_write=0, id_ex_bubble=0 (ID_EX holds). The EX slot is held.
  - ex_branch_taken is ignored.
  - Counter decrements each cycle; when it equals 1, next state is RUN.
  - ID is therefore stalled for exactly MC_LAT-1 cycles after issue.
- MC_LAT=1: MC_BUSY is never entered; the op behaves like a single-cycle op.
- Leaving MC_BUSY: the first RUN cycle evaluates hazards normally against the held EX slot (a multi-cycle op is never a load, so no load_use).
- stall_count: +1 every cycle pc_write=0, saturating at all-ones. A flush does not count.
- Register 0 is never a hazard source.
- Reset asserted mid-MC_BUSY or mid-stall: the next cycle is the reset state. No partial counts are retained.

Decomposition:
- Shared package holds RW, state encoding (RUN=0, MC_BUSY=1), and an EX-slot struct/field-width constants reused by the ID and EX stages.
- One natural sub-module, hazard_ctrl_sat_counter: a generic saturating counter used for stall_count.

Test Plan:
- Reset, then idle with id_valid=0 → pc_write=1, if_id_write=1, flush=0, bubble=0, stall_count=0.
- lw $5 issued, next ID add reads rs=5 → 1 cycle: pc_write=0, if_id_write=0, bubble=1; next cycle all advance; stall_count=1.
- lw $0 issued, next ID reads rs=0 → no stall.
- mul issued (MC_LAT=4) → ex_busy=1 and pc_write=0 for 3 cycles; fourth cycle RUN; stall_count=3.
- load_use and ex_branch_taken in the same cycle → flush=1, bubble=1, pc_write=1; stall_count unchanged.
- reset asserted 2nd cycle of MC_BUSY → next cycle state RUN, ex_busy=0, stall_count=0.
- Force 65535+ stall cycles → stall_count holds 16'hFFFF.
